// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer that owns the PC and hands one word per pulse to the decoder.
// Optional memory-response timeout is compiled in by defining FETCH_CTRL_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        en_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        dec_rd_en_o,
    output logic [31:0] dec_data_o,
    output logic [31:0] pc_o,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ISSUE, DRAIN} state_t;

    localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buffer;
    logic [31:0] redirect_pc;
    logic [31:0] pc_inc;
    logic        tmo_hit;
    logic        unused_ok;

    assign redirect_pc = {redirect_pc_i[31:2], 2'b00};
    assign pc_inc      = pc + 32'd4;

`ifdef FETCH_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;
    logic          tmo_run;

    // Counts consecutive response-less cycles while the FSM stays in WAIT or DRAIN.
    assign tmo_run   = !mem_rvalid_i && ((state == WAIT && !redirect_i) || state == DRAIN);
    assign tmo_hit   = tmo_run && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign unused_ok = ^redirect_pc_i[1:0];
`else
    assign tmo_hit   = 1'b0;
    assign err_o     = 1'b0;
    assign unused_ok = ^{redirect_pc_i[1:0], 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            pc          <= RESET_WORD;
            buffer      <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= RESET_WORD;
            dec_rd_en_o <= 1'b0;
            dec_data_o  <= '0;
            pc_o        <= RESET_WORD;
            busy_o      <= 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
            tmo_cnt     <= '0;
            err_o       <= 1'b0;
`endif
        end else begin
            dec_rd_en_o <= 1'b0;
`ifdef FETCH_CTRL_TIMEOUT_EN
            tmo_cnt     <= tmo_run ? tmo_cnt + CW'(1) : '0;
            if (tmo_hit) begin
                err_o <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (redirect_i) begin
                        pc <= redirect_pc;
                    end else if (en_i && !err_o) begin
                        state      <= REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc;
                        busy_o     <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect_i) begin
                        pc <= redirect_pc;
                    end
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (redirect_i) begin
                            state <= DRAIN;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (redirect_i) begin
                        mem_addr_o <= redirect_pc;
                    end
                end
                WAIT: begin
                    // A redirect here orphans the outstanding response, so it must be drained.
                    if (redirect_i) begin
                        pc <= redirect_pc;
                        if (mem_rvalid_i) begin
                            state      <= REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= redirect_pc;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (mem_rvalid_i) begin
                        buffer <= mem_rdata_i;
                        if (stall_i) begin
                            state <= HOLD;
                        end else begin
                            state       <= ISSUE;
                            dec_rd_en_o <= 1'b1;
                            dec_data_o  <= mem_rdata_i;
                            pc_o        <= pc;
                        end
                    end else if (tmo_hit) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc         <= redirect_pc;
                        state      <= REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= redirect_pc;
                    end else if (!stall_i) begin
                        state       <= ISSUE;
                        dec_rd_en_o <= 1'b1;
                        dec_data_o  <= buffer;
                        pc_o        <= pc;
                    end
                end
                ISSUE: begin
                    if (redirect_i) begin
                        pc         <= redirect_pc;
                        state      <= REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= redirect_pc;
                    end else begin
                        pc <= pc_inc;
                        if (en_i) begin
                            state      <= REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= pc_inc;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Further redirects only retarget the PC; the stale response is still owed.
                    if (redirect_i) begin
                        pc <= redirect_pc;
                    end
                    if (mem_rvalid_i) begin
                        if (en_i) begin
                            state      <= REQ;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= redirect_i ? redirect_pc : pc;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a word-stream reference model.
// The model expects pulses to walk consecutive words from the latest reset/redirect target.
module tb_fetch_ctrl;
    logic        clk_i         = 1'b0;
    logic        rstn_i        = 1'b0;
    logic        en_i          = 1'b0;
    logic        mem_gnt_i     = 1'b0;
    logic        mem_rvalid_i  = 1'b0;
    logic [31:0] mem_rdata_i   = '0;
    logic        stall_i       = 1'b0;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        dec_rd_en_o;
    logic [31:0] dec_data_o;
    logic [31:0] pc_o;
    logic        busy_o;
    logic        err_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_pulses = 0;
    logic [31:0] exp_pc   = '0;
    bit          prev_pulse = 1'b0;
    bit          drop_resp  = 1'b0;
    int          gnt_pct  = 100;
    int          min_lat  = 0;
    int          max_lat  = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    fetch_ctrl dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .en_i         (en_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .dec_rd_en_o  (dec_rd_en_o),
        .dec_data_o   (dec_data_o),
        .pc_o         (pc_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: a word's value is its own address mixed with a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h1305_0500;
    endfunction

    task automatic do_reset(input logic en);
        rstn_i        = 1'b0;
        en_i          = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        exp_pc     = 32'h0;
        prev_pulse = 1'b0;
        drop_resp  = 1'b0;
        gnt_pct    = 100;
        min_lat    = 0;
        max_lat    = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        en_i   = en;
        cyc    = 0;
    endtask

    // One clock: update the model for the cycle ending, observe after the edge, then drive memory.
    task automatic tick();
        logic req_no_gnt;
        if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
        req_no_gnt = mem_req_o && !mem_gnt_i;
        @(posedge clk_i);
        #1;
        cyc++;
        if (req_no_gnt) begin
            n_checks++;
            if (mem_req_o !== 1'b1) $display("[TB] FAIL req_withdrawn: mem_req_o=%b required 1 (cycle %0d)", mem_req_o, cyc);
            else n_pass++;
        end
        if (mem_req_o === 1'b1) begin
            n_checks++;
            if (mem_addr_o[1:0] !== 2'b00) $display("[TB] FAIL addr_align: mem_addr_o=%h low bits must be 0", mem_addr_o);
            else n_pass++;
        end
        if (dec_rd_en_o === 1'b1) begin
            n_checks++;
            if (prev_pulse) $display("[TB] FAIL back_to_back: dec_rd_en_o high on consecutive cycles (cycle %0d)", cyc);
            else n_pass++;
            n_checks++;
            if (pc_o !== exp_pc) $display("[TB] FAIL pulse_pc: pc_o=%h expected %h (cycle %0d)", pc_o, exp_pc, cyc);
            else n_pass++;
            n_checks++;
            if (dec_data_o !== mem_word(exp_pc)) $display("[TB] FAIL pulse_data: dec_data_o=%h expected %h", dec_data_o, mem_word(exp_pc));
            else n_pass++;
            exp_pc = exp_pc + 32'd4;
            n_pulses++;
        end
        prev_pulse = (dec_rd_en_o === 1'b1);

        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom();
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend_addr.pop_front());
            pend_due.delete(0);
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o === 1'b1 && $urandom_range(0, 99) < gnt_pct) begin
            mem_gnt_i = 1'b1;
            if (!drop_resp) begin
                pend_addr.push_back(mem_addr_o);
                pend_due.push_back(cyc + 1 + int'($urandom_range(min_lat, max_lat)));
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        repeat (4) tick();
        rstn_i = 1'b0;
        #1;
        n_checks++; if (mem_req_o !== 1'b0) $display("[TB] FAIL rst_req: got %b expected 0", mem_req_o); else n_pass++;
        n_checks++; if (mem_addr_o !== 32'h0) $display("[TB] FAIL rst_addr: got %h expected 0", mem_addr_o); else n_pass++;
        n_checks++; if (dec_rd_en_o !== 1'b0) $display("[TB] FAIL rst_rd_en: got %b expected 0", dec_rd_en_o); else n_pass++;
        n_checks++; if (dec_data_o !== 32'h0) $display("[TB] FAIL rst_data: got %h expected 0", dec_data_o); else n_pass++;
        n_checks++; if (pc_o !== 32'h0) $display("[TB] FAIL rst_pc: got %h expected 0", pc_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL rst_err: got %b expected 0", err_o); else n_pass++;
    endtask

    task automatic test_basic();
        logic exp_p;
        do_reset(1'b1);
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (n == 1) begin
                n_checks++;
                if (mem_req_o !== 1'b1) $display("[TB] FAIL req_rise: got %b expected 1", mem_req_o); else n_pass++;
            end
            exp_p = (n % 3 == 0);
            n_checks++;
            if (dec_rd_en_o !== exp_p) $display("[TB] FAIL pulse_timing: cycle %0d got %b expected %b", n, dec_rd_en_o, exp_p);
            else n_pass++;
            if (exp_p) begin
                n_checks++;
                if (pc_o !== 32'((n / 3 - 1) * 4)) $display("[TB] FAIL basic_pc: got %h expected %h", pc_o, 32'((n / 3 - 1) * 4));
                else n_pass++;
            end
            if (n == 3) begin
                n_checks++;
                if (dec_data_o !== 32'h1305_0500) $display("[TB] FAIL basic_data: got %h expected 13050500", dec_data_o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        bit found;
        do_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (mem_rvalid_i === 1'b1);
        end
        n_checks++;
        if (!found) $display("[TB] FAIL stall_rvalid: got no response expected one within 10 cycles"); else n_pass++;
        stall_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (dec_rd_en_o !== 1'b0) $display("[TB] FAIL hold_no_pulse: hold cycle %0d got %b expected 0", k, dec_rd_en_o); else n_pass++;
            n_checks++;
            if (busy_o !== 1'b1) $display("[TB] FAIL hold_busy: got %b expected 1", busy_o); else n_pass++;
            if (k == 4) stall_i = 1'b0;
        end
        tick();
        n_checks++;
        if (dec_rd_en_o !== 1'b1) $display("[TB] FAIL stall_release_pulse: got %b expected 1", dec_rd_en_o); else n_pass++;
        n_checks++;
        if (dec_data_o !== mem_word(32'h0)) $display("[TB] FAIL stall_data: got %h expected %h", dec_data_o, mem_word(32'h0)); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit found;
        do_reset(1'b1);
        min_lat = 2;
        max_lat = 2;
        tick();
        min_lat = 0;
        max_lat = 0;
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        for (int n = 3; n <= 5; n++) begin
            tick();
            redirect_i = 1'b0;
            n_checks++;
            if (dec_rd_en_o !== 1'b0) $display("[TB] FAIL stale_pulse: cycle %0d got %b expected 0", n, dec_rd_en_o); else n_pass++;
        end
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0100)
            $display("[TB] FAIL redirect_req: req=%b addr=%h expected req=1 addr=00000100", mem_req_o, mem_addr_o);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (dec_rd_en_o === 1'b1);
        end
        n_checks++;
        if (!found || pc_o !== 32'h0000_0100) $display("[TB] FAIL redirect_pulse: seen=%b pc_o=%h expected pulse at 00000100", found, pc_o);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit found;
        do_reset(1'b0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) $display("[TB] FAIL idle_redirect: busy=%b req=%b expected 0 0", busy_o, mem_req_o);
        else n_pass++;
        redirect_i = 1'b0;
        en_i       = 1'b1;
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hFFFF_FFFC)
            $display("[TB] FAIL wrap_req: req=%b addr=%h expected req=1 addr=fffffffc", mem_req_o, mem_addr_o);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = (dec_rd_en_o === 1'b1);
        end
        n_checks++;
        if (!found || pc_o !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_pulse: seen=%b pc_o=%h expected fffffffc", found, pc_o);
        else n_pass++;
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) $display("[TB] FAIL wrap_next: req=%b addr=%h expected req=1 addr=0", mem_req_o, mem_addr_o);
        else n_pass++;
    endtask

    task automatic test_en_drop();
        int start_pulses;
        do_reset(1'b1);
        gnt_pct = 0;
        tick();
        n_checks++;
        if (mem_req_o !== 1'b1) $display("[TB] FAIL drop_req_start: got %b expected 1", mem_req_o); else n_pass++;
        en_i = 1'b0;
        start_pulses = n_pulses;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (mem_req_o !== 1'b1) $display("[TB] FAIL req_held: got %b expected 1", mem_req_o); else n_pass++;
        end
        gnt_pct = 100;
        repeat (12) tick();
        n_checks++;
        if (n_pulses - start_pulses !== 1) $display("[TB] FAIL drop_pulses: got %0d expected 1", n_pulses - start_pulses); else n_pass++;
        n_checks++;
        if (busy_o !== 1'b0 || mem_req_o !== 1'b0) $display("[TB] FAIL drop_idle: busy=%b req=%b expected 0 0", busy_o, mem_req_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset(1'b1);
        drop_resp = 1'b1;
`ifdef FETCH_CTRL_TIMEOUT_EN
        for (int n = 1; n <= 30; n++) begin
            tick();
            n_checks++;
            if (err_o !== (n >= 18)) $display("[TB] FAIL timeout_err: cycle %0d got %b expected %b", n, err_o, (n >= 18)); else n_pass++;
            if (n >= 18) begin
                n_checks++;
                if (mem_req_o !== 1'b0) $display("[TB] FAIL timeout_halt: got req=%b expected 0", mem_req_o); else n_pass++;
            end
        end
`else
        for (int n = 1; n <= 40; n++) begin
            tick();
            n_checks++;
            if (err_o !== 1'b0) $display("[TB] FAIL no_timeout_err: cycle %0d got %b expected 0", n, err_o); else n_pass++;
        end
        n_checks++;
        if (busy_o !== 1'b1) $display("[TB] FAIL no_timeout_wait: busy=%b expected 1", busy_o); else n_pass++;
`endif
        drop_resp = 1'b0;
    endtask

    task automatic test_random();
        int  start_pulses;
        bit  idle_seen;
        do_reset(1'b1);
        gnt_pct      = 60;
        min_lat      = 0;
        max_lat      = 3;
        start_pulses = n_pulses;
        for (int i = 0; i < 3000; i++) begin
            tick();
            en_i       = ($urandom_range(0, 99) < 90);
            stall_i    = ($urandom_range(0, 99) < 25);
            redirect_i = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) redirect_pc_i = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else redirect_pc_i = $urandom();
        end
        en_i       = 1'b0;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        gnt_pct    = 100;
        idle_seen  = 1'b0;
        for (int i = 0; i < 40 && !idle_seen; i++) begin
            tick();
            idle_seen = (busy_o === 1'b0);
        end
        n_checks++;
        if (!idle_seen) $display("[TB] FAIL random_drain: busy_o=%b expected 0 within 40 cycles", busy_o); else n_pass++;
        n_checks++;
        if (n_pulses - start_pulses <= 100) $display("[TB] FAIL random_progress: got %0d pulses expected more than 100", n_pulses - start_pulses);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_wrap();
        test_en_drop();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer in front of the instruction decoder. It owns the program counter and issues one word read per instruction over a req/gnt/rvalid memory port. It hands each returned word to the decoder as a one-cycle read-enable pulse with the data, and applies control-flow redirects. The raw little-endian word is forwarded unchanged; byte reordering stays in the decoder.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- TIMEOUT_CYCLES, 16, WAIT/DRAIN cycles without rvalid before error (used only with FETCH_CTRL_TIMEOUT_EN); minimum 1
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- en_i  in  1  fetch enable
- mem_req_o  out  1  read request
- mem_addr_o  out  32  word address of request, [1:0]=0
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; exactly one per granted request, earliest the cycle after gnt
- mem_rdata_i  in  32  read data
- stall_i  in  1  decoder/downstream not ready
- redirect_i  in  1  load new PC (branch/jump taken)
- redirect_pc_i  in  32  redirect target; [1:0] ignored, forced 0
- dec_rd_en_o  out  1  one-cycle pulse; drives decoder rd_en_i
- dec_data_o  out  32  instruction word, valid while dec_rd_en_o=1
- pc_o  out  32  address of word on dec_data_o
- busy_o  out  1  FSM not in IDLE
- err_o  out  1  sticky memory timeout (0 when macro undefined)

## Operation
- States: IDLE, REQ, WAIT, HOLD, ISSUE, DRAIN; all outputs registered, Moore-style.
- IDLE: if en_i, go to REQ with mem_addr_o=pc.
- REQ: mem_req_o=1, held until mem_gnt_i; addr stable unless redirected. On gnt, go to WAIT.
- WAIT: on mem_rvalid_i, capture mem_rdata_i into buffer. Go to ISSUE if !stall_i, else HOLD.
- HOLD: buffer held; go to ISSUE on the first cycle stall_i=0.
- ISSUE: dec_rd_en_o=1, dec_data_o=buffer, pc_o=pc; pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0). Next state is REQ if en_i, else IDLE.
- DRAIN: discard the next rvalid, then go to REQ with the redirected pc. Go to IDLE instead if en_i=0.
- Redirect has priority over all other transitions in every state. pc<={redirect_pc_i[31:2],2'b00}, and:
  - IDLE: pc updated only; stay IDLE.
  - REQ without gnt: go to REQ with the new address next cycle.
  - REQ with gnt same cycle: go to DRAIN.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid same cycle: drop data; go to REQ.
  - HOLD: buffer dropped; go to REQ.
  - ISSUE: the pulse already on dec_rd_en_o is not cancelled; incremented pc discarded; go to REQ.
- en_i low mid-transaction: a granted or pending request completes and issues; the FSM then enters IDLE. mem_req_o is never withdrawn before gnt.
- dec_rd_en_o never asserted on consecutive cycles.

## Timing
- Reset (async assert, sync release): state IDLE, pc=RESET_PC, mem_req_o=0, mem_addr_o=RESET_PC, dec_rd_en_o=0, dec_data_o=0, pc_o=RESET_PC, busy_o=0, err_o=0.
- en_i sampled high in IDLE: mem_req_o rises the next cycle.
- Best case per instruction is 3 cycles: REQ (gnt same cycle), WAIT (rvalid), ISSUE. The next REQ follows ISSUE immediately.
- Each stall cycle adds one HOLD cycle.
- Redirect to first request at the new address: 1 cycle, plus DRAIN time if a response is outstanding.

## Configuration
- FETCH_CTRL_TIMEOUT_EN defined:
  - A counter runs in WAIT and DRAIN and clears on rvalid or state exit.
  - When it reaches TIMEOUT_CYCLES, err_o is set to 1 (sticky until reset) and the FSM goes to IDLE.
  - Fetching stays halted and en_i is ignored until reset.
- FETCH_CTRL_TIMEOUT_EN undefined: no counter, err_o tied 0, WAIT/DRAIN wait indefinitely.

## Test plan
- Reset release with en_i=1, gnt same cycle, rvalid next cycle, data 32'h13050500 -> dec_rd_en_o pulses at cycles 3, 6, 9 after release, with pc_o=0, 4, 8.
- rvalid with stall_i=1 for 4 cycles -> 4 HOLD cycles; single pulse with captured data on the cycle after stall_i falls.
- Redirect to 32'h0000_0103 in WAIT (rvalid 2 cycles later) -> stale word never pulsed; next request address 32'h0000_0100; pc_o=32'h100 on next pulse.
- RESET_PC=32'hFFFF_FFFC -> first pulse pc_o=32'hFFFF_FFFC; next request mem_addr_o=0.
- en_i dropped while in REQ without gnt -> mem_req_o held until gnt; one pulse issued; IDLE; busy_o=0.
- Macro defined, TIMEOUT_CYCLES=16, rvalid never returns -> err_o=1 on the 16th WAIT cycle; no further mem_req_o until reset. Macro undefined -> err_o stays 0.
